ysyx_22041412_idu_stage: RTL and testbench

//  Registered RV32/RV64 instruction-decode pipeline stage between IFU and EXU.
//  - Decodes fields, immediate, operand-select types, M-extension enable and illegal-instruction flag.
//  - Carries PC through with a valid/ready handshake.
//  - Two-entry skid buffer gives full throughput while keeping in_ready registered.

---
 rtl/ysyx_22041412_idu_stage.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22041412_idu_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_idu_stage.sv
// Instruction-decode pipeline stage: combinational RV32/RV64 decode into a registered output,
// with a two-entry (main + skid) buffer so in_ready stays a flop output at full throughput.
module ysyx_22041412_idu_stage #(
  parameter int unsigned     XLEN  = 64,
  parameter int unsigned     MEXT  = 1,
  parameter logic [XLEN-1:0] RSTPC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_v1type,
  output logic [1:0]      out_v2type,
  output logic            out_mul_en,
  output logic            out_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpReg32  = 7'b0111011;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  logic            s_valid;
  logic [31:0]     s_instr;
  logic [XLEN-1:0] s_pc;
  logic            in_fire;

  // While the skid holds an entry it is always older than anything on the input.
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;

  fmt_e            fmt;
  logic            legal;
  logic            is_op;
  logic            m_enc;
  logic [1:0]      v1type;
  logic [1:0]      v2type;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;

  assign in_ready  = ~s_valid;
  assign in_fire   = in_valid & in_ready;
  assign src_instr = s_valid ? s_instr : in_instr;
  assign src_pc    = s_valid ? s_pc : in_pc;

  always_comb begin
    fmt    = FmtR;
    legal  = 1'b1;
    is_op  = 1'b0;
    v1type = 2'd0;
    v2type = 2'd0;
    case (src_instr[6:0])
      OpLui:                   fmt = FmtU;
      OpAuipc:  begin fmt = FmtU; v1type = 2'd1; end
      OpJal:    begin fmt = FmtJ; v1type = 2'd1; end
      OpJalr, OpLoad, OpImm:   fmt = FmtI;
      OpSystem: begin
        fmt = FmtI;
        // csrrwi/csrrsi/csrrci take the zero-extended rs1 field as operand
        if (src_instr[14] && (src_instr[13:12] != 2'b00)) v1type = 2'd2;
      end
      OpBranch: begin fmt = FmtB; v2type = 2'd1; end
      OpStore:                 fmt = FmtS;
      OpReg:    begin is_op = 1'b1; v2type = 2'd1; end
      OpImm32: begin
        if (XLEN == 64) fmt = FmtI;
        else            legal = 1'b0;
      end
      OpReg32: begin
        if (XLEN == 64) begin
          is_op  = 1'b1;
          v2type = 2'd1;
        end else begin
          legal = 1'b0;
        end
      end
      default:                 legal = 1'b0;
    endcase

    m_enc = is_op && (src_instr[31:25] == 7'b0000001);

    case (fmt)
      FmtI:    imm32 = {{20{src_instr[31]}}, src_instr[31:20]};
      FmtS:    imm32 = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
      FmtB:    imm32 = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25], src_instr[11:8],
                        1'b0};
      FmtU:    imm32 = {src_instr[31:12], 12'b0};
      FmtJ:    imm32 = {{12{src_instr[31]}}, src_instr[19:12], src_instr[20], src_instr[30:21],
                        1'b0};
      default: imm32 = 32'b0;
    endcase
    imm = XLEN'($signed(imm32));

    rs1 = (fmt == FmtU || fmt == FmtJ) ? 5'd0 : src_instr[19:15];
    rs2 = (fmt == FmtI || fmt == FmtU || fmt == FmtJ) ? 5'd0 : src_instr[24:20];
    rd  = (fmt == FmtS || fmt == FmtB) ? 5'd0 : src_instr[11:7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      s_valid     <= 1'b0;
      s_instr     <= '0;
      s_pc        <= '0;
      out_pc      <= RSTPC;
      out_opcode  <= '0;
      out_func3   <= '0;
      out_func7   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_v1type  <= '0;
      out_v2type  <= '0;
      out_mul_en  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Main register free this cycle: refill from skid first, else from the input.
      s_valid   <= 1'b0;
      out_valid <= s_valid | in_valid;
      if (s_valid || in_valid) begin
        out_pc      <= src_pc;
        out_opcode  <= src_instr[6:0];
        out_func3   <= src_instr[14:12];
        out_func7   <= src_instr[30];
        out_rs1     <= rs1;
        out_rs2     <= rs2;
        out_rd      <= rd;
        out_imm     <= imm;
        out_v1type  <= v1type;
        out_v2type  <= v2type;
        out_mul_en  <= m_enc && (MEXT != 0);
        out_illegal <= !legal || (m_enc && (MEXT == 0));
      end
    end else if (in_fire) begin
      s_valid <= 1'b1;
      s_instr <= in_instr;
      s_pc    <= in_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_idu_stage.sv
// Bench: two stage instances (RV64+M, RV32 without M) share one input stream; a queue-based
// occupancy/order model plus a rule-based decoder checks every cycle.
module tb_ysyx_22041412_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_func7, a_mul, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [6:0]  a_op;
  logic [2:0]  a_f3;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [1:0]  a_v1, a_v2;

  logic        b_in_ready, b_out_valid, b_func7, b_mul, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [6:0]  b_op;
  logic [2:0]  b_f3;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_v1, b_v2;

  ysyx_22041412_idu_stage #(.XLEN(64), .MEXT(1), .RSTPC(64'h0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_func3(a_f3), .out_func7(a_func7), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_v1type(a_v1), .out_v2type(a_v2),
    .out_mul_en(a_mul), .out_illegal(a_ill)
  );

  ysyx_22041412_idu_stage #(.XLEN(32), .MEXT(0), .RSTPC(32'h0000_1000)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_func3(b_f3), .out_func7(b_func7), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm), .out_v1type(b_v1), .out_v2type(b_v2),
    .out_mul_en(b_mul), .out_illegal(b_ill)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [1:0]  v1, v2;
    logic        mul, ill;
  } obs_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  int    errors = 0;
  int    checks = 0;
  int    popped = 0;
  bit    saw_low = 0;
  item_t q[$];
  obs_t  obs_a, obs_b;

  always_comb begin
    obs_a = '{pc: a_pc, op: a_op, f3: a_f3, f7: a_func7, rs1: a_rs1, rs2: a_rs2, rd: a_rd,
              imm: a_imm, v1: a_v1, v2: a_v2, mul: a_mul, ill: a_ill};
    obs_b = '{pc: {32'h0, b_pc}, op: b_op, f3: b_f3, f7: b_func7, rs1: b_rs1, rs2: b_rs2,
              rd: b_rd, imm: {32'h0, b_imm}, v1: b_v1, v2: b_v2, mul: b_mul, ill: b_ill};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode from the ISA rules: format from opcode, immediate assembled arithmetically.
  function automatic obs_t exp_obs(input item_t it, input int xlen, input int mext);
    obs_t        o;
    logic [31:0] ins;
    logic [6:0]  op;
    byte         fmt;
    bit          legal, is_op, m_enc;
    longint      s, sg, hi, imm;
    ins   = it.instr;
    op    = ins[6:0];
    legal = 1;
    is_op = 0;
    case (op)
      7'h37, 7'h17:               fmt = "U";
      7'h6f:                      fmt = "J";
      7'h67, 7'h03, 7'h13, 7'h73: fmt = "I";
      7'h23:                      fmt = "S";
      7'h63:                      fmt = "B";
      7'h33: begin fmt = "R"; is_op = 1; end
      7'h1b: begin fmt = (xlen == 64) ? "I" : "R"; legal = (xlen == 64); end
      7'h3b: begin fmt = "R"; legal = (xlen == 64); is_op = (xlen == 64); end
      default: begin fmt = "R"; legal = 0; end
    endcase
    s  = longint'($signed(ins));
    sg = s >>> 31;
    case (fmt)
      "I": imm = s >>> 20;
      "S": begin hi = s >>> 25; imm = hi * 32 + longint'(ins[11:7]); end
      "B": imm = sg * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                 + longint'(ins[11:8]) * 2;
      "U": begin hi = s >>> 12; imm = hi * 4096; end
      "J": imm = sg * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                 + longint'(ins[30:21]) * 2;
      default: imm = 0;
    endcase
    m_enc = is_op && (ins[31:25] == 7'd1);
    o.pc  = (xlen == 32) ? {32'h0, it.pc[31:0]} : it.pc;
    o.imm = (xlen == 32) ? {32'h0, imm[31:0]} : imm;
    o.op  = op;
    o.f3  = ins[14:12];
    o.f7  = ins[30];
    o.rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : ins[19:15];
    o.rs2 = (fmt == "I" || fmt == "U" || fmt == "J") ? 5'd0 : ins[24:20];
    o.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : ins[11:7];
    o.v1  = (op == 7'h6f || op == 7'h17) ? 2'd1 : (op == 7'h73 && ins[14:12] >= 3'd5) ? 2'd2
                                                                                      : 2'd0;
    o.v2  = (is_op || op == 7'h63) ? 2'd1 : 2'd0;
    o.mul = m_enc && (mext != 0);
    o.ill = !legal || (m_enc && (mext == 0));
    return o;
  endfunction

  task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
    chk({t, "_pc"}, a.pc, e.pc);
    chk({t, "_opcode"}, a.op, e.op);
    chk({t, "_func3"}, a.f3, e.f3);
    chk({t, "_func7"}, a.f7, e.f7);
    chk({t, "_rs1"}, a.rs1, e.rs1);
    chk({t, "_rs2"}, a.rs2, e.rs2);
    chk({t, "_rd"}, a.rd, e.rd);
    chk({t, "_imm"}, a.imm, e.imm);
    chk({t, "_v1type"}, a.v1, e.v1);
    chk({t, "_v2type"}, a.v2, e.v2);
    chk({t, "_mul_en"}, a.mul, e.mul);
    chk({t, "_illegal"}, a.ill, e.ill);
  endtask

  // Every cycle: occupancy and head-of-queue against the model, then step the model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("a_out_valid", a_out_valid, q.size() > 0);
      chk("a_in_ready", a_in_ready, q.size() < 2);
      chk("b_out_valid", b_out_valid, q.size() > 0);
      chk("b_in_ready", b_in_ready, q.size() < 2);
      if (!a_in_ready) saw_low = 1;
      if (q.size() > 0) begin
        cmp_obs("a", obs_a, exp_obs(q[0], 64, 1));
        cmp_obs("b", obs_b, exp_obs(q[0], 32, 0));
      end
      if (flush) begin
        q.delete();
      end else begin
        bit can_take;
        can_take = q.size() < 2;
        if (q.size() > 0 && out_ready) begin
          void'(q.pop_front());
          popped++;
        end
        if (in_valid && can_take) q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [14];
    logic [31:0] ins;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h1b,
            7'h3b, 7'h7f, 7'h0b};
    ins      = $urandom;
    ins[6:0] = ops[$urandom_range(0, 13)];
    if ($urandom_range(0, 3) == 0) ins[31:25] = 7'b0000001;
    return ins;
  endfunction

  // IFU/EXU driver: in_valid is held until accepted (or flushed away).
  task automatic drive(input int cycles, input int stall_lo, input int stall_hi,
                       input int flush_pct, input int valid_pct, input int ready_pct,
                       input int max_items);
    int issued;
    bit fire, flushed;
    issued = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fire    = in_valid && a_in_ready;
      flushed = flush;
      @(posedge clk);
      #1;
      if (!(in_valid && !fire && !flushed)) begin
        in_valid = (issued < max_items) && ($urandom_range(0, 99) < valid_pct);
        if (in_valid) begin
          in_instr = rand_instr();
          in_pc    = in_pc + 64'd4;
          issued++;
        end
      end
      out_ready = (c >= stall_lo && c < stall_hi) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      flush     = $urandom_range(0, 99) < flush_pct;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] ins, input logic [63:0] pc);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  obs_t m;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_pc", a_pc, 64'h0);
    chk("rst_a_imm", a_imm, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_illegal", a_ill, 0);
    chk("rst_b_pc", b_pc, 32'h0000_1000);
    chk("rst_b_in_ready", b_in_ready, 1);

    // Hand-derived values pinning the reference decoder.
    m = exp_obs('{instr: 32'h0051_0093, pc: 64'h0}, 64, 1);
    chk("model_addi_rd", m.rd, 1);
    chk("model_addi_imm", m.imm, 64'd5);
    m = exp_obs('{instr: 32'hFFDF_F0EF, pc: 64'h0}, 32, 0);
    chk("model_jal_imm32", m.imm, 64'h0000_0000_FFFF_FFFC);
    m = exp_obs('{instr: 32'h0220_81B3, pc: 64'h0}, 32, 0);
    chk("model_mul_nomext_ill", m.ill, 1);

    @(posedge clk);
    #1;
    rst = 1'b0;

    send_one(32'h0051_0093, 64'h8000_0000);
    chk("t1_valid", a_out_valid, 1);
    chk("t1_rd", a_rd, 1);
    chk("t1_rs1", a_rs1, 2);
    chk("t1_rs2", a_rs2, 0);
    chk("t1_imm", a_imm, 64'd5);
    chk("t1_v2type", a_v2, 0);
    chk("t1_pc", a_pc, 64'h8000_0000);
    send_one(32'h1234_52B7, 64'h8000_0004);
    chk("t2_lui_imm", a_imm, 64'h0000_0000_1234_5000);
    chk("t2_lui_rs1", a_rs1, 0);
    chk("t2_lui_v1type", a_v1, 0);
    send_one(32'hFFDF_F0EF, 64'h8000_0008);
    chk("t2_jal_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t2_jal_v1type", a_v1, 1);
    send_one(32'h0220_81B3, 64'h8000_000C);
    chk("t3_mul_en_a", a_mul, 1);
    chk("t3_v2type_a", a_v2, 1);
    chk("t3_illegal_b", b_ill, 1);
    chk("t3_mul_en_b", b_mul, 0);
    send_one(32'h0010_809B, 64'h8000_0010);
    chk("t4_opimm32_ill_b", b_ill, 1);
    chk("t4_opimm32_ok_a", a_ill, 0);
    send_one(32'h0000_D073, 64'h8000_0014);
    chk("t4_csrrwi_v1type_b", b_v1, 2);

    // Eight back-to-back instructions with a three-cycle output stall.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    popped  = 0;
    saw_low = 0;
    in_pc   = 64'h0000_0000_8000_1000;
    drive(20, 3, 6, 0, 100, 100, 8);
    chk("t5_all_delivered", popped, 8);
    chk("t5_in_ready_fell", saw_low, 1);
    chk("t5_model_empty", q.size(), 0);

    // Fill main and skid, then flush with a pending input.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000_0013;
    in_pc     = 64'h100;
    @(posedge clk);
    #1;
    in_instr = 32'h0010_0093;
    in_pc    = 64'h104;
    @(posedge clk);
    #1;
    in_instr = 32'h0020_0113;
    in_pc    = 64'h108;
    flush    = 1'b1;
    @(negedge clk);
    chk("t6_skid_full", a_in_ready, 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", a_out_valid, 0);
    chk("t6_in_ready", a_in_ready, 1);
    repeat (3) @(posedge clk);

    in_pc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
    drive(3000, -1, -1, 3, 70, 70, 1 << 30);
    chk("rand_model_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
